// File: rtl/rob_pkg.sv
// rob_pkg: shared widths and index types for the reorder buffer
package rob_pkg;
  localparam int SCALAR  = 2;
  localparam int ROB_SZ  = 32;
  localparam int ROB_IDX = 5;
  localparam int ARF_IDX = 5;
  localparam int PRF_IDX = 6;
  typedef logic [ROB_IDX-1:0] rob_idx_t;
  typedef logic [ROB_IDX:0]   rob_cnt_t;
  typedef logic [ARF_IDX-1:0] arf_idx_t;
  typedef logic [PRF_IDX-1:0] prf_idx_t;
endpackage

// File: rtl/rob_if.sv
// rob_if: dispatch, completion and retire signals of the reorder buffer
interface rob_if;
  import rob_pkg::*;
  logic [SCALAR-1:0]         disp_valid;
  logic [SCALAR*ARF_IDX-1:0] disp_dest_idx;
  logic [SCALAR*PRF_IDX-1:0] disp_pdest_idx;
  logic [SCALAR-1:0]         disp_has_dest;
  logic [SCALAR-1:0]         disp_is_branch;
  logic [SCALAR*ROB_IDX-1:0] disp_rob_idx;
  logic                      disp_stall;
  logic [SCALAR-1:0]         cdb_valid;
  logic [SCALAR*ROB_IDX-1:0] cdb_rob_idx;
  logic [SCALAR-1:0]         cdb_mispredict;
  logic [SCALAR-1:0]         commit;
  logic [SCALAR-1:0]         retire_valid;
  logic [SCALAR*ARF_IDX-1:0] retire_dest_idx;
  logic [SCALAR*PRF_IDX-1:0] retire_pdest_idx;
  logic                      flush;
  rob_cnt_t                  rob_count;
  modport master (
    output disp_valid, disp_dest_idx, disp_pdest_idx, disp_has_dest, disp_is_branch,
    output cdb_valid, cdb_rob_idx, cdb_mispredict,
    input  disp_rob_idx, disp_stall, commit, retire_valid, retire_dest_idx,
    input  retire_pdest_idx, flush, rob_count
  );
  modport slave (
    input  disp_valid, disp_dest_idx, disp_pdest_idx, disp_has_dest, disp_is_branch,
    input  cdb_valid, cdb_rob_idx, cdb_mispredict,
    output disp_rob_idx, disp_stall, commit, retire_valid, retire_dest_idx,
    output retire_pdest_idx, flush, rob_count
  );
endinterface

// File: rtl/rob_entry.sv
// rob_entry: storage for one reorder-buffer slot with write, complete and clear
module rob_entry
  import rob_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     clr,
  input  logic     wr,
  input  logic     wr_has_dest,
  input  logic     wr_is_branch,
  input  arf_idx_t wr_dest,
  input  prf_idx_t wr_pdest,
  input  logic     cpl,
  input  logic     cpl_mispredict,
  output logic     valid,
  output logic     complete,
  output logic     mispredict,
  output logic     has_dest,
  output arf_idx_t dest,
  output prf_idx_t pdest
);
  logic is_branch;
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      valid      <= 1'b0;
      complete   <= 1'b0;
      mispredict <= 1'b0;
    end else if (wr) begin
      valid      <= 1'b1;
      complete   <= 1'b0;
      mispredict <= 1'b0;
      has_dest   <= wr_has_dest;
      is_branch  <= wr_is_branch;
      dest       <= wr_dest;
      pdest      <= wr_pdest;
    end else if (cpl && valid) begin
      complete   <= 1'b1;
      mispredict <= cpl_mispredict && is_branch;
    end
  end
endmodule

// File: rtl/rob.sv
// rob: 2-wide reorder buffer retiring out-of-order completions in program order
module rob
  import rob_pkg::*;
(
  input logic  clk,
  input logic  reset,
  rob_if.slave bus
);
  rob_idx_t head, tail, head1, tail1, cidx0, cidx1;
  rob_cnt_t count;
  logic [ROB_SZ-1:0] v, c, m, hd;
  arf_idx_t dest [ROB_SZ];
  prf_idx_t pdest [ROB_SZ];
  logic [SCALAR-1:0] acc, ret;
  assign head1 = head + rob_idx_t'(1);
  assign tail1 = tail + rob_idx_t'(1);
  assign cidx0 = bus.cdb_rob_idx[0 +: ROB_IDX];
  assign cidx1 = bus.cdb_rob_idx[ROB_IDX +: ROB_IDX];
  assign bus.disp_stall = count > rob_cnt_t'(ROB_SZ - 2);
  assign acc = (bus.disp_stall || bus.flush) ? '0 : bus.disp_valid;
  assign ret[0] = v[head] && c[head];
  assign ret[1] = ret[0] && !m[head] && v[head1] && c[head1];
  assign bus.flush = (ret[0] && m[head]) || (ret[1] && m[head1]);
  assign bus.retire_valid = ret;
  assign bus.commit = ret & {hd[head1], hd[head]};
  assign bus.retire_dest_idx = {dest[head1], dest[head]};
  assign bus.retire_pdest_idx = {pdest[head1], pdest[head]};
  assign bus.disp_rob_idx = {tail1, tail};
  assign bus.rob_count = count;
  for (genvar e = 0; e < ROB_SZ; e++) begin : g_ent
    localparam rob_idx_t idx = rob_idx_t'(e);
    logic w1, c1, wr, cpl, clr;
    assign w1  = acc[1] && tail1 == idx;
    assign wr  = w1 || (acc[0] && tail == idx);
    assign c1  = bus.cdb_valid[1] && cidx1 == idx;
    assign cpl = c1 || (bus.cdb_valid[0] && cidx0 == idx);
    assign clr = bus.flush || (ret[0] && head == idx) || (ret[1] && head1 == idx);
    rob_entry u_entry (
      .clk           (clk),
      .reset         (reset),
      .clr           (clr),
      .wr            (wr),
      .wr_has_dest   (bus.disp_has_dest[w1]),
      .wr_is_branch  (bus.disp_is_branch[w1]),
      .wr_dest       (w1 ? bus.disp_dest_idx[ARF_IDX +: ARF_IDX] : bus.disp_dest_idx[0 +: ARF_IDX]),
      .wr_pdest      (w1 ? bus.disp_pdest_idx[PRF_IDX +: PRF_IDX] : bus.disp_pdest_idx[0 +: PRF_IDX]),
      .cpl           (cpl),
      .cpl_mispredict(c1 ? bus.cdb_mispredict[1] : bus.cdb_mispredict[0]),
      .valid         (v[e]),
      .complete      (c[e]),
      .mispredict    (m[e]),
      .has_dest      (hd[e]),
      .dest          (dest[e]),
      .pdest         (pdest[e])
    );
  end
  // a retiring mispredict squashes everything younger, so pointers restart at zero
  always_ff @(posedge clk) begin
    if (!reset || bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + rob_idx_t'(ret[0]) + rob_idx_t'(ret[1]);
      tail  <= tail + rob_idx_t'(acc[0]) + rob_idx_t'(acc[1]);
      count <= count + rob_cnt_t'(acc[0]) + rob_cnt_t'(acc[1]) - rob_cnt_t'(ret[0]) - rob_cnt_t'(ret[1]);
    end
  end
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer for the 2-wide out-of-order core; sits directly downstream of the rename stage (RAT + free list).
- Accepts up to two renamed instructions per cycle, each carrying its arch dest and newly allocated PRF dest.
- Records completion broadcasts from the CDB and retires up to two completed instructions per cycle, in program order.
- Drives the RAT's commit, retire_dest_idx_in and retire_pdest_idx_in, and drives flush on a mispredicted-branch retire.

Parameters:
- SCALAR, 2, dispatch/complete/retire width (the design supports only 2)
- ROB_SZ, 32, entry count (power of two)
- ROB_IDX, 5, log2(ROB_SZ)
- ARF_IDX, 5, architectural register index width
- PRF_IDX, 6, physical register index width

Ports:
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk
- disp_valid  in  SCALAR  per-lane dispatch request; lanes packed (lane1 valid implies lane0 valid)
- disp_dest_idx  in  SCALAR*ARF_IDX  arch dest per lane
- disp_pdest_idx  in  SCALAR*PRF_IDX  PRF dest from the rename stage per lane
- disp_has_dest  in  SCALAR  lane writes a register
- disp_is_branch  in  SCALAR  lane is a branch
- disp_rob_idx  out  SCALAR*ROB_IDX  entry assigned to each lane (tail, tail+1 mod ROB_SZ)
- disp_stall  out  1  fewer than 2 free entries
- cdb_valid  in  SCALAR  completion broadcast per lane
- cdb_rob_idx  in  SCALAR*ROB_IDX  completing entry
- cdb_mispredict  in  SCALAR  completing branch was mispredicted
- commit  out  SCALAR  retire with dest write (feeds RAT commit)
- retire_valid  out  SCALAR  instruction retires (any kind)
- retire_dest_idx  out  SCALAR*ARF_IDX  arch dest of retiring lane
- retire_pdest_idx  out  SCALAR*PRF_IDX  PRF dest of retiring lane
- flush  out  1  mispredicted branch retiring this cycle
- rob_count  out  ROB_IDX+1  occupied entries

Behaviour:
- State per entry: valid, complete, mispredict, has_dest, dest, pdest. Global state: head, tail (ROB_IDX bits, wrap mod ROB_SZ) and count (0..ROB_SZ).
- Reset (reset==0 at posedge): head=tail=count=0 and all valid/complete bits cleared. Outputs then read commit=0, retire_valid=0, flush=0, disp_stall=0, rob_count=0. Reset overrides every other input, including mid-retire.
- Dispatch:
  - Lanes are accepted when disp_valid is set, disp_stall=0 and flush=0.
  - An accepted lane writes entry tail+lane with complete=0.
  - tail advances by the number of accepted lanes.
  - A request made while stalled or flushing is dropped; upstream holds it.
  - disp_rob_idx is combinational from tail.
- disp_stall = (count > ROB_SZ-2), combinational from registered count.
- Completion:
  - cdb_valid sets complete, and sets mispredict from cdb_mispredict, on the next edge.
  - A broadcast to an invalid entry is ignored.
  - Two lanes naming the same entry: lane1 wins.
  - Completion and retire of the same entry in one cycle is illegal; upstream guarantees it cannot happen.
- Retire (combinational from registered state, zero latency):
  - Lane0 retires if head is valid and complete.
  - Lane1 retires if lane0 retires, head is not mispredicted, and head+1 is valid and complete.
  - commit[i] = retire_valid[i] & has_dest.
  - flush = lane0 retires and head mispredicted, OR lane1 retires and head+1 mispredicted.
- Retire update: head advances by the number of retired lanes and those entries are invalidated.
- Flush edge: all entries invalidated; head=tail=count=0; dispatch and completion in that cycle are discarded.
- count_next = count + accepted − retired. Simultaneous dispatch and retire is legal at full, empty, and at pointer wrap (e.g. tail=31 dispatching 2 writes entries 31 and 0).
- No retire when empty; lane1 never retires past tail.

Decomposition:
- Shared defines: SCALAR, ROB_SZ, ROB_IDX, PRF_IDX, ARF_IDX, the `SEL lane-slice macro and `SD.
- One sub-module, rob_entry: a single entry's storage with write, complete and clear ports.
- The top level holds the pointers, count, retire select and flush.

Test Plan:
- Reset low for 2 cycles, then dispatch 2 lanes (dest 3/4, pdest 33/34) → disp_rob_idx=0/1, rob_count=2, commit=0.
- CDB completes entry 1 only → no retire. Then complete entry 0 → same cycle commit=2'b11, retire_pdest 33/34; next cycle rob_count=0.
- Dispatch 15×2 lanes without completion → rob_count=30, disp_stall=0. One more pair → rob_count=32, disp_stall=1. A further request is dropped and tail is unchanged.
- Head pointer at 31: dispatch 2 → entries 31 and 0. Complete both → both retire in one cycle and head wraps to 1.
- Branch at head completes with mispredict=1, younger entry complete → retire_valid=2'b01, flush=1. Next cycle rob_count=0, and the dispatch presented during the flush cycle is ignored.
- Assert reset mid-stream with 5 entries occupied and CDB active → next cycle everything is 0. A completion to old index 2 afterwards is ignored.
